// File: rtl/proc_control.sv
// Instruction sequencer for the 16-bit datapath: latches IR from din,
// steps T0..T3 and drives bus-mux select plus register load strobes.
module proc_control #(
  parameter int word = 16
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            run,
  input  logic [word-1:0] din,
  output logic            ir_in,
  output logic [7:0]      r_in,
  output logic            a_in,
  output logic            g_in,
  output logic            addsub,
  output logic [9:0]      select,
  output logic            done,
  output logic [8:0]      ir
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  state_t state, nxt;

  logic [2:0] op;
  logic [2:0] x;
  logic [2:0] y;
  logic [7:0] xd;
  logic [7:0] yd;
  logic       is_mv;
  logic       is_mvi;
  logic       is_alu;

  assign op     = ir[8:6];
  assign x      = ir[5:3];
  assign y      = ir[2:0];
  assign xd     = 8'b1 << x;
  assign yd     = 8'b1 << y;
  assign is_mv  = (op == 3'b000);
  assign is_mvi = (op == 3'b001);
  assign is_alu = (op[2:1] == 2'b01);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= nxt;
      if (state == T0 && run)
        ir <= din[word-1 -: 9];
    end
  end

  always_comb begin
    nxt    = state;
    ir_in  = 1'b0;
    r_in   = '0;
    a_in   = 1'b0;
    g_in   = 1'b0;
    addsub = 1'b0;
    select = '0;
    done   = 1'b0;
    unique case (state)
      T0: begin
        ir_in = run;
        if (run)
          nxt = T1;
      end
      T1: begin
        unique case (1'b1)
          is_mv: begin
            select = {yd, 2'b00};
            r_in   = xd;
            done   = 1'b1;
            nxt    = T0;
          end
          is_mvi: begin
            select = 10'h001;
            r_in   = xd;
            done   = 1'b1;
            nxt    = T0;
          end
          is_alu: begin
            select = {xd, 2'b00};
            a_in   = 1'b1;
            nxt    = T2;
          end
          default: begin
            // reserved opcodes retire with no side effects
            done = 1'b1;
            nxt  = T0;
          end
        endcase
      end
      T2: begin
        select = {yd, 2'b00};
        g_in   = 1'b1;
        addsub = op[0];
        nxt    = T3;
      end
      T3: begin
        select = 10'h002;
        r_in   = xd;
        done   = 1'b1;
        nxt    = T0;
      end
      default: nxt = T0;
    endcase
  end

endmodule

// File: tb/tb_proc_control.sv
// Directed, table-driven bench for proc_control.
// Outputs sampled 1 time unit after the falling edge.
module tb_proc_control;

  logic        clock = 1'b0;
  logic        resetn;
  logic        run;
  logic [15:0] din;
  logic        ir_in;
  logic [7:0]  r_in;
  logic        a_in;
  logic        g_in;
  logic        addsub;
  logic [9:0]  select;
  logic        done;
  logic [8:0]  ir;

  int tests = 0;
  int fails = 0;

  proc_control #(.word(16)) dut (
    .clock  (clock),
    .resetn (resetn),
    .run    (run),
    .din    (din),
    .ir_in  (ir_in),
    .r_in   (r_in),
    .a_in   (a_in),
    .g_in   (g_in),
    .addsub (addsub),
    .select (select),
    .done   (done),
    .ir     (ir)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       ir_in;
    logic [7:0] r_in;
    logic       a_in;
    logic       g_in;
    logic       addsub;
    logic [9:0] select;
    logic       done;
    logic [8:0] ir;
  } outs_t;

  typedef struct {
    logic       run;
    logic [8:0] i;
    outs_t      exp;
  } vec_t;

  function automatic outs_t e(
    logic ii, logic [7:0] r, logic a, logic g,
    logic s, logic [9:0] sel, logic d, logic [8:0] irv);
    outs_t o;
    o = '{ii, r, a, g, s, sel, d, irv};
    return o;
  endfunction

  function automatic logic [15:0] mk(logic [8:0] i);
    return {i, 7'h55};
  endfunction

  function automatic outs_t cur();
    outs_t o;
    o = '{ir_in, r_in, a_in, g_in, addsub, select, done, ir};
    return o;
  endfunction

  task automatic chk(string name, outs_t exp);
    outs_t a;
    a = cur();
    tests++;
    if (a !== exp) begin
      fails++;
      $display("FAIL %s: got ir_in=%b r_in=%h a=%b g=%b as=%b sel=%h done=%b ir=%h, want ir_in=%b r_in=%h a=%b g=%b as=%b sel=%h done=%b ir=%h",
        name, a.ir_in, a.r_in, a.a_in, a.g_in, a.addsub, a.select, a.done, a.ir,
        exp.ir_in, exp.r_in, exp.a_in, exp.g_in, exp.addsub, exp.select, exp.done, exp.ir);
    end
  endtask

  task automatic chkv(string name, logic [15:0] got, logic [15:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  vec_t v[21];

  initial begin
    logic [8:0] dmask;
    logic [8:0] fmask;
    logic [15:0] bdin[9];

    v[0]  = '{1'b1, 9'h058, e(1, 8'h00, 0, 0, 0, 10'h000, 0, 9'h000)};
    v[1]  = '{1'b0, 9'h1ff, e(0, 8'h08, 0, 0, 0, 10'h001, 1, 9'h058)};
    v[2]  = '{1'b1, 9'h02b, e(1, 8'h00, 0, 0, 0, 10'h000, 0, 9'h058)};
    v[3]  = '{1'b0, 9'h000, e(0, 8'h20, 0, 0, 0, 10'h020, 1, 9'h02b)};
    v[4]  = '{1'b1, 9'h081, e(1, 8'h00, 0, 0, 0, 10'h000, 0, 9'h02b)};
    v[5]  = '{1'b0, 9'h000, e(0, 8'h00, 1, 0, 0, 10'h004, 0, 9'h081)};
    v[6]  = '{1'b0, 9'h000, e(0, 8'h00, 0, 1, 0, 10'h008, 0, 9'h081)};
    v[7]  = '{1'b0, 9'h000, e(0, 8'h01, 0, 0, 0, 10'h002, 1, 9'h081)};
    v[8]  = '{1'b1, 9'h0c1, e(1, 8'h00, 0, 0, 0, 10'h000, 0, 9'h081)};
    v[9]  = '{1'b0, 9'h000, e(0, 8'h00, 1, 0, 0, 10'h004, 0, 9'h0c1)};
    v[10] = '{1'b0, 9'h000, e(0, 8'h00, 0, 1, 1, 10'h008, 0, 9'h0c1)};
    v[11] = '{1'b0, 9'h000, e(0, 8'h01, 0, 0, 0, 10'h002, 1, 9'h0c1)};
    v[12] = '{1'b1, 9'h1d2, e(1, 8'h00, 0, 0, 0, 10'h000, 0, 9'h0c1)};
    v[13] = '{1'b0, 9'h000, e(0, 8'h00, 0, 0, 0, 10'h000, 1, 9'h1d2)};
    v[14] = '{1'b0, 9'h081, e(0, 8'h00, 0, 0, 0, 10'h000, 0, 9'h1d2)};
    v[15] = '{1'b0, 9'h081, e(0, 8'h00, 0, 0, 0, 10'h000, 0, 9'h1d2)};
    v[16] = '{1'b1, 9'h092, e(1, 8'h00, 0, 0, 0, 10'h000, 0, 9'h1d2)};
    v[17] = '{1'b1, 9'h1ff, e(0, 8'h00, 1, 0, 0, 10'h010, 0, 9'h092)};
    v[18] = '{1'b0, 9'h0c1, e(0, 8'h00, 0, 1, 0, 10'h010, 0, 9'h092)};
    v[19] = '{1'b1, 9'h1ff, e(0, 8'h04, 0, 0, 0, 10'h002, 1, 9'h092)};
    v[20] = '{1'b0, 9'h000, e(0, 8'h00, 0, 0, 0, 10'h000, 0, 9'h092)};

    resetn = 1'b0;
    run    = 1'b0;
    din    = 16'h0000;
    #2;
    chk("reset_idle", e(0, 8'h00, 0, 0, 0, 10'h000, 0, 9'h000));
    run = 1'b1;
    din = mk(9'h058);
    #1;
    chk("reset_run", e(1, 8'h00, 0, 0, 0, 10'h000, 0, 9'h000));

    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 21; i++) begin
      run = v[i].run;
      din = mk(v[i].i);
      #1;
      chk($sformatf("vec%0d", i), v[i].exp);
      @(negedge clock);
    end

    // reset pulsed during T2 of a sub
    run = 1'b1;
    din = mk(9'h0c1);
    #1;
    chk("abort_fetch", e(1, 8'h00, 0, 0, 0, 10'h000, 0, 9'h092));
    @(negedge clock);
    run = 1'b0;
    #1;
    chk("abort_t1", e(0, 8'h00, 1, 0, 0, 10'h004, 0, 9'h0c1));
    @(negedge clock);
    #1;
    chk("abort_t2", e(0, 8'h00, 0, 1, 1, 10'h008, 0, 9'h0c1));
    resetn = 1'b0;
    #1;
    chk("abort_rst", e(0, 8'h00, 0, 0, 0, 10'h000, 0, 9'h000));
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("abort_idle%0d", i),
          e(0, 8'h00, 0, 0, 0, 10'h000, 0, 9'h000));
      @(negedge clock);
    end
    run = 1'b1;
    din = mk(9'h02b);
    #1;
    chk("refetch_t0", e(1, 8'h00, 0, 0, 0, 10'h000, 0, 9'h000));
    @(negedge clock);
    run = 1'b0;
    #1;
    chk("refetch_t1", e(0, 8'h20, 0, 0, 0, 10'h020, 1, 9'h02b));
    @(negedge clock);

    // back-to-back mvi, add, mv with run held high
    for (int i = 0; i < 9; i++) bdin[i] = 16'hffff;
    bdin[0] = mk(9'h058);
    bdin[2] = mk(9'h081);
    bdin[6] = mk(9'h02b);
    bdin[8] = mk(9'h000);
    dmask = '0;
    fmask = '0;
    run = 1'b1;
    for (int i = 0; i < 9; i++) begin
      din = bdin[i];
      #1;
      dmask[i] = done;
      fmask[i] = ir_in;
      @(negedge clock);
    end
    run = 1'b0;
    chkv("b2b_done", {7'b0, dmask}, 16'h00a2);
    chkv("b2b_fetch", {7'b0, fmask}, 16'h0145);
    #1;
    chk("b2b_last", e(0, 8'h01, 0, 0, 0, 10'h004, 1, 9'h000));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
